headgen_pipe_sn: RTL and testbench

- Parametrised N-stage header-generator pipeline. Successor to the fixed 3-stage, 9+16+16-bit header pipe.
- Carries one control word plus LANES data lanes per beat.
- Adds valid/ready backpressure with bubble collapsing, synchronous flush, an output-enable gate and an occupancy count.
- Sits between the header field builder and the frame assembler in the encapsulation datapath.

---
 rtl/headgen_pipe_sn.sv | 135 +++++++++++++
 tb/tb_headgen_pipe_sn.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/headgen_pipe_sn.sv
// Parametrised DEPTH-stage header pipe carrying one control word plus LANES data lanes per beat.
// Latency: DEPTH cycles from push into an empty pipe to out_valid; one beat per clock sustained.
// Backpressure: valid/ready with bubble collapsing; in_ready is combinational from out_ready/enableout.
// Optional: define HEADGEN_PIPE_STAT_EN to add hdr_cnt, a wrapping count of popped end-of-header beats.
module headgen_pipe_sn #(
    parameter int C_W   = 9,
    parameter int D_W   = 16,
    parameter int LANES = 2,
    parameter int DEPTH = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [C_W-1:0]               in_ctrl,
    input  logic [LANES*D_W-1:0]         in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [C_W-1:0]               out_ctrl,
    output logic [LANES*D_W-1:0]         out_data,
    input  logic                         enableout,
    input  logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef HEADGEN_PIPE_STAT_EN
    ,
    output logic [15:0]                  hdr_cnt
`endif
);

    localparam int DW    = LANES * D_W;
    localparam int OCC_W = $clog2(DEPTH + 1);

    // Per-stage state; stage DEPTH-1 is the head presented downstream.
    logic [DEPTH-1:0] v_q, v_d;
    logic [C_W-1:0]   c_q [DEPTH];
    logic [C_W-1:0]   c_d [DEPTH];
    logic [DW-1:0]    d_q [DEPTH];
    logic [DW-1:0]    d_d [DEPTH];
    logic [OCC_W-1:0] occ_q, occ_d;

    logic [DEPTH-1:0] mv;
    logic             out_vld;
    logic             push;
    logic             pop;

    // Handshake and move chain: a stage advances when the next one is empty or emptying.
    always_comb begin
        out_vld = v_q[DEPTH-1] & enableout & ~flush;
        pop     = out_vld & out_ready;
        mv      = '0;
        mv[DEPTH-1] = pop;
        for (int s = DEPTH - 2; s >= 0; s--) begin
            mv[s] = v_q[s] & (~v_q[s+1] | mv[s+1]);
        end
        in_ready = ~flush & (~v_q[0] | mv[0]);
        push     = in_valid & in_ready;
    end

    // Next-state for stages and occupancy; flush drops every valid bit and leaves payload stale.
    always_comb begin
        v_d   = v_q;
        c_d   = c_q;
        d_d   = d_q;
        occ_d = occ_q;
        for (int s = DEPTH - 1; s >= 1; s--) begin
            if (mv[s-1]) begin
                c_d[s] = c_q[s-1];
                d_d[s] = d_q[s-1];
            end
            v_d[s] = mv[s-1] | (v_q[s] & ~mv[s]);
        end
        if (push) begin
            c_d[0] = in_ctrl;
            d_d[0] = in_data;
        end
        v_d[0] = push | (v_q[0] & ~mv[0]);
        if (push && !pop) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (pop && !push) begin
            occ_d = occ_q - OCC_W'(1);
        end
        if (flush) begin
            v_d   = '0;
            occ_d = '0;
        end
    end

    // Stage and occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q   <= '0;
            occ_q <= '0;
            for (int s = 0; s < DEPTH; s++) begin
                c_q[s] <= '0;
                d_q[s] <= '0;
            end
        end else begin
            v_q   <= v_d;
            occ_q <= occ_d;
            c_q   <= c_d;
            d_q   <= d_d;
        end
    end

    assign out_valid = out_vld;
    assign out_ctrl  = out_vld ? c_q[DEPTH-1] : '0;
    assign out_data  = out_vld ? d_q[DEPTH-1] : '0;
    assign occupancy = occ_q;

`ifdef HEADGEN_PIPE_STAT_EN
    logic [15:0] hdr_cnt_q, hdr_cnt_d;

    // Count popped beats carrying the end-of-header marker; wraps naturally, survives flush.
    always_comb begin
        hdr_cnt_d = hdr_cnt_q;
        if (pop && c_q[DEPTH-1][C_W-1]) begin
            hdr_cnt_d = hdr_cnt_q + 16'd1;
        end
    end

    // Statistics register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hdr_cnt_q <= '0;
        end else begin
            hdr_cnt_q <= hdr_cnt_d;
        end
    end

    assign hdr_cnt = hdr_cnt_q;
`else
    // No statistics counter in this build.
`endif

endmodule

// File: tb/tb_headgen_pipe_sn.sv
module tb_headgen_pipe_sn;

    localparam int DEPTH = 3;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  in_ctrl;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [8:0]  out_ctrl;
    logic [31:0] out_data;
    logic        enableout;
    logic        flush;
    logic [1:0]  occupancy;
`ifdef HEADGEN_PIPE_STAT_EN
    logic [15:0] hdr_cnt;
`endif

    headgen_pipe_sn #(.C_W(9), .D_W(16), .LANES(2), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .enableout (enableout),
        .flush     (flush),
        .occupancy (occupancy)
`ifdef HEADGEN_PIPE_STAT_EN
        ,
        .hdr_cnt   (hdr_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: FIFO of beats with age = clock edges since accepted.
    typedef struct {
        logic [8:0]  c;
        logic [31:0] d;
        int          age;
    } beat_t;
    beat_t q[$];
    int    exp_hdr = 0;

    typedef struct {
        logic        iv;
        logic [8:0]  ic;
        logic [31:0] id;
        logic        ordy;
        logic        en;
        logic        fl;
        logic        eov;
        logic        eir;
        logic [1:0]  eocc;
        logic [8:0]  ectl;
        logic [31:0] edat;
    } vec_t;
    vec_t tbl[23];

    function automatic vec_t mk(input logic iv, input logic [8:0] ic, input logic [31:0] id,
                                input logic ordy, input logic en, input logic fl,
                                input logic eov, input logic eir, input logic [1:0] eocc,
                                input logic [8:0] ectl, input logic [31:0] edat);
        vec_t v;
        v.iv = iv; v.ic = ic; v.id = id; v.ordy = ordy; v.en = en; v.fl = fl;
        v.eov = eov; v.eir = eir; v.eocc = eocc; v.ectl = ectl; v.edat = edat;
        return v;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [8:0] ic, input logic [31:0] id,
                         input logic ordy, input logic en, input logic fl);
        in_valid  = iv;
        in_ctrl   = ic;
        in_data   = id;
        out_ready = ordy;
        enableout = en;
        flush     = fl;
    endtask

    // Position of each queued beat: the oldest rises to the head, each younger one
    // sits at least one stage behind its predecessor, and nobody rises faster than its age.
    task automatic positions(output int p[$]);
        p.delete();
        for (int i = 0; i < q.size(); i++) begin
            if (i == 0) p.push_back(imin(q[i].age, DEPTH - 1));
            else        p.push_back(imin(q[i].age, p[i-1] - 1));
        end
    endtask

    // Compare DUT against the model for the current cycle, then advance the model one edge.
    task automatic model_step();
        int          p[$];
        int          np[$];
        bit          e_ov, pop, free0, e_ir;
        logic [8:0]  ec;
        logic [31:0] ed;
        positions(p);
        e_ov = (q.size() > 0) && (p[0] == DEPTH - 1) && enableout && !flush;
        ec   = e_ov ? q[0].c : 9'h0;
        ed   = e_ov ? q[0].d : 32'h0;
        chk("m_out_valid", 64'(out_valid), 64'(e_ov));
        chk("m_out_ctrl",  64'(out_ctrl),  64'(ec));
        chk("m_out_data",  64'(out_data),  64'(ed));
        chk("m_occupancy", 64'(occupancy), 64'(q.size()));
`ifdef HEADGEN_PIPE_STAT_EN
        chk("m_hdr_cnt", 64'(hdr_cnt), 64'(exp_hdr));
`endif
        pop = e_ov && out_ready;
        if (pop) begin
            if (q[0].c[8]) exp_hdr = (exp_hdr + 1) % 65536;
            void'(q.pop_front());
        end
        for (int i = 0; i < q.size(); i++) q[i].age = q[i].age + 1;
        positions(np);
        free0 = (q.size() == 0) || (np[q.size()-1] > 0);
        e_ir  = !flush && free0;
        chk("m_in_ready", 64'(in_ready), 64'(e_ir));
        if (in_valid && e_ir) q.push_back('{c: in_ctrl, d: in_data, age: 0});
        if (flush) q.delete();
    endtask

    task automatic finish_cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 9'h0, 32'h0, 1'b1, 1'b1, 1'b0);
        rst = 1'b0;
        q.delete();
        exp_hdr = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Single beat, back-to-back stream, then backpressure with 5 offered beats.
        tbl[0]  = mk(1, 9'h155, 32'h0000_003F, 1, 1, 0,  0, 1, 0, 9'h000, 32'h0);
        tbl[1]  = mk(0, 9'h000, 32'h0,         1, 1, 0,  0, 1, 1, 9'h000, 32'h0);
        tbl[2]  = mk(0, 9'h000, 32'h0,         1, 1, 0,  0, 1, 1, 9'h000, 32'h0);
        tbl[3]  = mk(0, 9'h000, 32'h0,         1, 1, 0,  1, 1, 1, 9'h155, 32'h0000_003F);
        tbl[4]  = mk(0, 9'h000, 32'h0,         1, 1, 0,  0, 1, 0, 9'h000, 32'h0);
        tbl[5]  = mk(1, 9'h155, 32'h003F_FC00, 1, 1, 0,  0, 1, 0, 9'h000, 32'h0);
        tbl[6]  = mk(1, 9'h155, 32'hFFFF_FFFF, 1, 1, 0,  0, 1, 1, 9'h000, 32'h0);
        tbl[7]  = mk(1, 9'h000, 32'h003F_FC00, 1, 1, 0,  0, 1, 2, 9'h000, 32'h0);
        tbl[8]  = mk(0, 9'h000, 32'h0,         1, 1, 0,  1, 1, 3, 9'h155, 32'h003F_FC00);
        tbl[9]  = mk(0, 9'h000, 32'h0,         1, 1, 0,  1, 1, 2, 9'h155, 32'hFFFF_FFFF);
        tbl[10] = mk(0, 9'h000, 32'h0,         1, 1, 0,  1, 1, 1, 9'h000, 32'h003F_FC00);
        tbl[11] = mk(0, 9'h000, 32'h0,         1, 1, 0,  0, 1, 0, 9'h000, 32'h0);
        tbl[12] = mk(1, 9'h010, 32'hD000_A000, 0, 1, 0,  0, 1, 0, 9'h000, 32'h0);
        tbl[13] = mk(1, 9'h011, 32'hD001_A001, 0, 1, 0,  0, 1, 1, 9'h000, 32'h0);
        tbl[14] = mk(1, 9'h012, 32'hD002_A002, 0, 1, 0,  0, 1, 2, 9'h000, 32'h0);
        tbl[15] = mk(1, 9'h013, 32'hD003_A003, 0, 1, 0,  1, 0, 3, 9'h010, 32'hD000_A000);
        tbl[16] = mk(1, 9'h013, 32'hD003_A003, 0, 1, 0,  1, 0, 3, 9'h010, 32'hD000_A000);
        tbl[17] = mk(1, 9'h013, 32'hD003_A003, 1, 1, 0,  1, 1, 3, 9'h010, 32'hD000_A000);
        tbl[18] = mk(1, 9'h014, 32'hD004_A004, 1, 1, 0,  1, 1, 3, 9'h011, 32'hD001_A001);
        tbl[19] = mk(0, 9'h000, 32'h0,         1, 1, 0,  1, 1, 3, 9'h012, 32'hD002_A002);
        tbl[20] = mk(0, 9'h000, 32'h0,         1, 1, 0,  1, 1, 2, 9'h013, 32'hD003_A003);
        tbl[21] = mk(0, 9'h000, 32'h0,         1, 1, 0,  1, 1, 1, 9'h014, 32'hD004_A004);
        tbl[22] = mk(0, 9'h000, 32'h0,         1, 1, 0,  0, 1, 0, 9'h000, 32'h0);

        do_reset();
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_ctrl",  64'(out_ctrl),  64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        finish_cycle();

        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].iv, tbl[i].ic, tbl[i].id, tbl[i].ordy, tbl[i].en, tbl[i].fl);
            @(negedge clk);
            chk($sformatf("tbl%0d_out_valid", i), 64'(out_valid), 64'(tbl[i].eov));
            chk($sformatf("tbl%0d_in_ready", i),  64'(in_ready),  64'(tbl[i].eir));
            chk($sformatf("tbl%0d_occupancy", i), 64'(occupancy), 64'(tbl[i].eocc));
            chk($sformatf("tbl%0d_out_ctrl", i),  64'(out_ctrl),  64'(tbl[i].ectl));
            chk($sformatf("tbl%0d_out_data", i),  64'(out_data),  64'(tbl[i].edat));
            finish_cycle();
        end

        // enableout=0: fill to full, output gated, then resume on the re-enable cycle.
        for (int i = 0; i < 3; i++) begin
            drive(1, 9'h0A0 + 9'(i), 32'hE000_0000 + 32'(i), 1, 0, 0);
            @(negedge clk);
            finish_cycle();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1, 9'h0A3, 32'hE000_0003, 1, 0, 0);
            @(negedge clk);
            chk("en0_out_valid", 64'(out_valid), 64'd0);
            chk("en0_out_data",  64'(out_data),  64'd0);
            chk("en0_occupancy", 64'(occupancy), 64'd3);
            chk("en0_in_ready",  64'(in_ready),  64'd0);
            finish_cycle();
        end
        drive(0, 9'h0, 32'h0, 1, 1, 0);
        @(negedge clk);
        chk("en1_out_valid", 64'(out_valid), 64'd1);
        chk("en1_out_ctrl",  64'(out_ctrl),  64'h0A0);
        chk("en1_out_data",  64'(out_data),  64'hE000_0000);
        finish_cycle();
        repeat (3) begin
            @(negedge clk);
            finish_cycle();
        end

        // flush with occupancy 2 and a simultaneous offer.
        for (int i = 0; i < 2; i++) begin
            drive(1, 9'h0F0 + 9'(i), 32'hF100_0000 + 32'(i), 1, 1, 0);
            @(negedge clk);
            finish_cycle();
        end
        drive(1, 9'h0F2, 32'hF100_0002, 1, 1, 1);
        @(negedge clk);
        chk("fl_occ_before", 64'(occupancy), 64'd2);
        chk("fl_in_ready",   64'(in_ready),  64'd0);
        chk("fl_out_valid",  64'(out_valid), 64'd0);
        finish_cycle();
        drive(0, 9'h0, 32'h0, 1, 1, 0);
        @(negedge clk);
        chk("fl_occ_after",  64'(occupancy), 64'd0);
        chk("fl_out_valid2", 64'(out_valid), 64'd0);
        finish_cycle();

        // Asynchronous reset while the head beat is valid.
        for (int i = 0; i < 3; i++) begin
            drive(1, 9'h1C0 + 9'(i), 32'hC0C0_0000 + 32'(i), 1, 1, 0);
            @(negedge clk);
            finish_cycle();
        end
        drive(1, 9'h1C3, 32'hC0C0_0003, 1, 1, 0);
        @(negedge clk);
        chk("ar_pre_out_valid", 64'(out_valid), 64'd1);
        rst = 1'b0;
        #1;
        chk("ar_out_valid", 64'(out_valid), 64'd0);
        chk("ar_occupancy", 64'(occupancy), 64'd0);
        chk("ar_out_ctrl",  64'(out_ctrl),  64'd0);
        q.delete();
        exp_hdr = 0;
        @(posedge clk);
        #1;
        drive(0, 9'h0, 32'h0, 1, 1, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("ar_rel_out_valid", 64'(out_valid), 64'd0);
        chk("ar_rel_occupancy", 64'(occupancy), 64'd0);
        chk("ar_rel_in_ready",  64'(in_ready),  64'd1);
        finish_cycle();

`ifdef HEADGEN_PIPE_STAT_EN
        // Four pops, two carrying the end-of-header marker.
        for (int i = 0; i < 8; i++) begin
            if (i < 4) drive(1, (i % 2 == 0) ? 9'h101 + 9'(i) : 9'h001 + 9'(i), 32'(i), 1, 1, 0);
            else       drive(0, 9'h0, 32'h0, 1, 1, 0);
            @(negedge clk);
            finish_cycle();
        end
        @(negedge clk);
        chk("hdr_cnt_two", 64'(hdr_cnt), 64'd2);
        finish_cycle();

        // Wrap: 65537 marked beats from reset leave the counter at 1.
        do_reset();
        for (int i = 0; i < 65537; i++) begin
            drive(1, 9'h100, $urandom, 1, 1, 0);
            @(negedge clk);
            finish_cycle();
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 9'h0, 32'h0, 1, 1, 0);
            @(negedge clk);
            finish_cycle();
        end
        @(negedge clk);
        chk("hdr_cnt_wrap", 64'(hdr_cnt), 64'd1);
        finish_cycle();
`endif

        // Randomised traffic against the model.
        for (int i = 0; i < 800; i++) begin
            drive($urandom_range(0, 9) < 7, 9'($urandom), $urandom,
                  $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 9,
                  $urandom_range(0, 19) == 0);
            @(negedge clk);
            finish_cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
